// File: rtl/cache_xbar_pkg.sv
// Shared crossbar package: default per-bank outstanding depth and
// the occupancy-width helper used by router, queue and interface.
package cache_xbar_pkg;

    localparam int unsigned DefaultMaxOutstanding = 32'd4;

    // Bits needed to count 0..depth inclusive.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/cache_bank_rsp_router_if.sv
// Bank-side request/response bundle of cache_bank_rsp_router.
// slave: router view; master: crossbar/bank/bench view.
import cache_xbar_pkg::*;

interface cache_bank_rsp_router_if #(
    parameter type         mst_sel_t = logic,
    parameter int unsigned OccW      = occ_width(DefaultMaxOutstanding)
);
    logic            req_valid_i;
    mst_sel_t        req_src_i;
    logic            bank_req_ready_i;
    logic            req_ready_o;
    logic            bank_rsp_valid_i;
    logic            bank_rsp_ready_o;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    mst_sel_t        rsp_sel_o;
    logic [OccW-1:0] outstanding_o;
    logic [31:0]     full_stall_cnt_o;
    logic            orphan_rsp_o;

    modport slave (
        input  req_valid_i, req_src_i, bank_req_ready_i,
        input  bank_rsp_valid_i, rsp_ready_i,
        output req_ready_o, bank_rsp_ready_o, rsp_valid_o,
        output rsp_sel_o, outstanding_o,
        output full_stall_cnt_o, orphan_rsp_o
    );

    modport master (
        output req_valid_i, req_src_i, bank_req_ready_i,
        output bank_rsp_valid_i, rsp_ready_i,
        input  req_ready_o, bank_rsp_ready_o, rsp_valid_o,
        input  rsp_sel_o, outstanding_o,
        input  full_stall_cnt_o, orphan_rsp_o
    );

endinterface

// File: rtl/cache_bank_rsp_route_fifo.sv
// In-order queue of winning core indices for one cache bank.
// Ports: clk_i/rst_i, push_i+data_i, pop_i, head_o, full_o, empty_o, count_o.
module cache_bank_rsp_route_fifo
    import cache_xbar_pkg::*;
#(
    parameter int unsigned Depth  = DefaultMaxOutstanding,
    parameter type         data_t = logic,
    localparam int unsigned OccW  = occ_width(Depth),
    localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  data_t           data_i,
    input  logic            pop_i,
    output data_t           head_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [OccW-1:0] count_o
);

    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    data_t           mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [OccW-1:0] count;

    // Explicit wrap so non-power-of-two depths stay in range.
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop_i) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push_i && !pop_i) begin
                count <= count + 1'b1;
            end else if (pop_i && !push_i) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head_o  = mem[rd_ptr];
    assign full_o  = (count == OccW'(Depth));
    assign empty_o = (count == '0);
    assign count_o = count;

endmodule

// File: rtl/cache_bank_rsp_router.sv
// Per-bank response router: queues request winners, steers responses in order.
// Ports: clk_i, rst_i (sync, active-high), bus (slave modport of
// cache_bank_rsp_router_if). Optional stall counter: CACHE_BANK_RSP_ROUTER_PERF_EN.
module cache_bank_rsp_router
    import cache_xbar_pkg::*;
#(
    parameter int unsigned NumInp         = 32'd0,
    parameter int unsigned MaxOutstanding = DefaultMaxOutstanding,
    parameter type mst_sel_t =
        logic [((NumInp > 1) ? $clog2(NumInp) : 1)-1:0]
) (
    input logic                    clk_i,
    input logic                    rst_i,
    cache_bank_rsp_router_if.slave bus
);

    localparam int unsigned OccW = occ_width(MaxOutstanding);

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    mst_sel_t        head;
    logic [OccW-1:0] count;
    logic            orphan_q;

    // Ready ignores same-cycle pop: no comb path from response side.
    assign bus.req_ready_o = bus.bank_req_ready_i & ~full & ~rst_i;
    assign push = bus.req_valid_i & bus.req_ready_o;

    assign bus.rsp_valid_o      = bus.bank_rsp_valid_i & ~empty & ~rst_i;
    assign bus.bank_rsp_ready_o = bus.rsp_ready_i & ~empty & ~rst_i;
    assign pop = bus.rsp_valid_o & bus.rsp_ready_i;

    assign bus.rsp_sel_o     = head;
    assign bus.outstanding_o = count;
    assign bus.orphan_rsp_o  = orphan_q;

    cache_bank_rsp_route_fifo #(
        .Depth  (MaxOutstanding),
        .data_t (mst_sel_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (bus.req_src_i),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // A response with nothing outstanding has no owner; latch it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            orphan_q <= 1'b0;
        end else if (bus.bank_rsp_valid_i && empty) begin
            orphan_q <= 1'b1;
        end
    end

`ifdef CACHE_BANK_RSP_ROUTER_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if (bus.req_valid_i && bus.bank_req_ready_i &&
                     full && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.full_stall_cnt_o = stall_q;
`else
    assign bus.full_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cache_bank_rsp_router.sv
// Bench for cache_bank_rsp_router: directed table, corner sequences
// and random traffic against a queue-based reference model.
module tb_cache_bank_rsp_router;
    import cache_xbar_pkg::*;

    typedef logic [2:0] sel_t;

    logic clk = 1'b0;
    logic rst;

    cache_bank_rsp_router_if #(.mst_sel_t(sel_t), .OccW(3)) bus();

    cache_bank_rsp_router #(
        .NumInp         (8),
        .MaxOutstanding (4),
        .mst_sel_t      (sel_t)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: plain queue of owners, sticky flag, stall count.
    int          mq[$];
    bit          m_orph = 1'b0;
    logic [31:0] m_cnt  = '0;

    logic        s_ready, s_rv, s_brro, s_orph;
    sel_t        s_sel;
    logic [2:0]  s_out;
    logic [31:0] s_cnt;

    typedef struct {
        bit         r, v;
        sel_t       s;
        bit         br, bv, rr;
        bit         e_ready, e_rv, e_brro;
        bit         chk_sel;
        sel_t       e_sel;
        logic [2:0] e_out;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit v, input sel_t s,
                       input bit br, input bit bv, input bit rr);
        bit empty, full, pop, push;
        logic [31:0] exp_cnt;
        rst                  = r;
        bus.req_valid_i      = v;
        bus.req_src_i        = s;
        bus.bank_req_ready_i = br;
        bus.bank_rsp_valid_i = bv;
        bus.rsp_ready_i      = rr;
        @(negedge clk);
        empty = (mq.size() == 0);
        full  = (mq.size() == 4);
        s_ready = bus.req_ready_o;
        s_rv    = bus.rsp_valid_o;
        s_brro  = bus.bank_rsp_ready_o;
        s_sel   = bus.rsp_sel_o;
        s_out   = bus.outstanding_o;
        s_orph  = bus.orphan_rsp_o;
        s_cnt   = bus.full_stall_cnt_o;
`ifdef CACHE_BANK_RSP_ROUTER_PERF_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = '0;
`endif
        chk("ready", s_ready, br && !full && !r);
        chk("rsp_valid", s_rv, bv && !empty && !r);
        chk("bank_rsp_ready", s_brro, rr && !empty && !r);
        chk("outstanding", s_out, mq.size());
        chk("orphan", s_orph, m_orph);
        chk("stall_cnt", s_cnt, exp_cnt);
        if (!empty && !r) chk("rsp_sel", s_sel, mq[0]);
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_orph = 1'b0;
            m_cnt  = '0;
        end else begin
            pop  = bv && !empty && rr;
            push = v && br && !full;
            if (bv && empty) m_orph = 1'b1;
            if (v && br && full && m_cnt != 32'hFFFF_FFFF) m_cnt++;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(int'(s));
        end
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        tbl[0]  = '{1,0,0,0,0,0, 0,0,0, 0,0,0};
        tbl[1]  = '{0,1,5,1,0,0, 1,0,0, 0,0,0};
        tbl[2]  = '{0,0,0,1,0,0, 1,0,0, 0,0,1};
        tbl[3]  = '{0,0,0,1,0,0, 1,0,0, 0,0,1};
        tbl[4]  = '{0,0,0,1,1,1, 1,1,1, 1,5,1};
        tbl[5]  = '{0,0,0,1,0,0, 1,0,0, 0,0,0};
        tbl[6]  = '{0,1,1,1,0,0, 1,0,0, 0,0,0};
        tbl[7]  = '{0,1,2,1,0,0, 1,0,0, 0,0,1};
        tbl[8]  = '{0,1,3,1,0,0, 1,0,0, 0,0,2};
        tbl[9]  = '{0,1,0,1,0,0, 1,0,0, 0,0,3};
        tbl[10] = '{0,1,6,1,0,0, 0,0,0, 0,0,4};
        tbl[11] = '{0,0,0,1,1,1, 0,1,1, 1,1,4};
        tbl[12] = '{0,0,0,1,1,1, 1,1,1, 1,2,3};
        tbl[13] = '{0,0,0,1,1,1, 1,1,1, 1,3,2};
        tbl[14] = '{0,0,0,1,1,1, 1,1,1, 1,0,1};
        tbl[15] = '{0,0,0,1,0,0, 1,0,0, 0,0,0};

        rst = 1'b1;
        bus.req_valid_i      = 1'b0;
        bus.req_src_i        = '0;
        bus.bank_req_ready_i = 1'b0;
        bus.bank_rsp_valid_i = 1'b0;
        bus.rsp_ready_i      = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_sel", bus.rsp_sel_o, 0);
        chk("reset_ready", bus.req_ready_o, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].r, tbl[i].v, tbl[i].s,
                tbl[i].br, tbl[i].bv, tbl[i].rr);
            chk("tbl_ready", s_ready, tbl[i].e_ready);
            chk("tbl_rsp_valid", s_rv, tbl[i].e_rv);
            chk("tbl_bank_rsp_ready", s_brro, tbl[i].e_brro);
            chk("tbl_outstanding", s_out, tbl[i].e_out);
            if (tbl[i].chk_sel) chk("tbl_rsp_sel", s_sel, tbl[i].e_sel);
        end

        // Full queue: pop and new request in the same cycle.
        cyc(0, 1, 4, 1, 0, 0);
        cyc(0, 1, 5, 1, 0, 0);
        cyc(0, 1, 6, 1, 0, 0);
        cyc(0, 1, 7, 1, 0, 0);
        cyc(0, 1, 2, 1, 1, 1);
        chk("full_pop_refused", s_ready, 0);
        chk("full_pop_occ4", s_out, 4);
        cyc(0, 1, 2, 1, 0, 0);
        chk("full_pop_accept", s_ready, 1);
        chk("full_pop_occ3", s_out, 3);
        idle();
        chk("full_pop_occ4b", s_out, 4);

        // Response crossbar stalls with the bank response held.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 1, 0);
            chk("stall_brro", s_brro, 0);
            chk("stall_sel", s_sel, 5);
        end
        cyc(0, 0, 0, 1, 1, 1);
        chk("stall_pop_valid", s_rv, 1);
        chk("stall_pop_sel", s_sel, 5);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1, 1);

        // Response while empty.
        cyc(0, 0, 0, 1, 1, 1);
        chk("orphan_no_valid", s_rv, 0);
        chk("orphan_no_ready", s_brro, 0);
        idle();
        chk("orphan_set", s_orph, 1);

        // Reset with two outstanding, then a late response.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 3, 1, 0, 0);
        cyc(0, 1, 4, 1, 0, 0);
        chk("pre_reset_occ", s_out, 1);
        cyc(1, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 1);
        chk("late_no_valid", s_rv, 0);
        chk("late_occ0", s_out, 0);
        idle();
        chk("late_orphan", s_orph, 1);
        chk("late_occ0b", s_out, 0);

        // Request held against a full queue for 10 cycles.
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, sel_t'(i), 1, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 7, 1, 0, 0);
        idle();
`ifdef CACHE_BANK_RSP_ROUTER_PERF_EN
        chk("stall_cnt_10", s_cnt, 10);
`else
        chk("stall_cnt_off", s_cnt, 0);
`endif
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, 1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 64) == 0,
                ($urandom % 10) < 7,
                sel_t'($urandom),
                ($urandom % 8) != 0,
                ($urandom % 2) == 0,
                ($urandom % 4) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_bank_rsp_router.md
# cache_bank_rsp_router

Per-bank response-routing tracker placed on the memory side of the cache crossbar, one instance per cache bank. It records which core won each accepted bank request (the crossbar's per-output selected index) in an in-order queue. It drives that index as the response-crossbar select when the bank returns the matching response. It also back-pressures the request path when the number of outstanding requests for the bank reaches a configured limit.

## Interface
Parameters:
- NumInp, 32'd0: number of cores / crossbar inputs (`> 0`).
- MaxOutstanding, 32'd4: queue depth, the maximum number of in-flight requests per bank (`≥ 1`).
- mst_sel_t, logic [$clog2(NumInp)-1:0]: core index type.

Ports:
- clk_i  input  1  clock, positive edge.
- rst_i  input  1  reset, synchronous, active-high.
- req_valid_i  input  1  crossbar request valid toward the bank.
- req_src_i  input  mst_sel_t  winning core index for the current request.
- bank_req_ready_i  input  1  bank request ready.
- req_ready_o  output  1  gated ready returned to the crossbar.
- bank_rsp_valid_i  input  1  bank response valid.
- bank_rsp_ready_o  output  1  ready to the bank.
- rsp_valid_o  output  1  response valid into the response crossbar.
- rsp_ready_i  input  1  response crossbar ready.
- rsp_sel_o  output  mst_sel_t  destination core of the head response.
- outstanding_o  output  $clog2(MaxOutstanding+1)  current queue occupancy.
- full_stall_cnt_o  output  32  stall counter (see Configuration).
- orphan_rsp_o  output  1  sticky error flag.

## Operation
- push = req_valid_i & bank_req_ready_i & ~full. On push, req_src_i is written at the tail.
- req_ready_o = bank_req_ready_i & ~full & ~rst_i.
  - req_ready_o does not depend on pop in the same cycle, so there is no combinational pop-to-ready path.
  - When the queue is full, a request is refused even if a pop occurs in the same cycle.
- Head handling:
  - rsp_sel_o = head entry.
  - rsp_valid_o = bank_rsp_valid_i & ~empty.
  - bank_rsp_ready_o = rsp_ready_i & ~empty.
- pop = rsp_valid_o & rsp_ready_i, which removes the head entry.
- Responses complete strictly in order: exactly one response per accepted request.
- Simultaneous push and pop: occupancy is unchanged, and pointers advance independently.
- Pointers wrap modulo MaxOutstanding. For non-power-of-two depths, the pointer wraps explicitly to 0 after MaxOutstanding-1.
- Empty queue:
  - A push is not visible at the head until the next cycle (no bypass).
  - bank_rsp_valid_i while empty produces no forwarding and bank_rsp_ready_o=0.
  - It also sets orphan_rsp_o, which stays set until reset.
- Reset mid-operation drops all entries. Any in-flight bank response after reset counts as an orphan.
- rsp_sel_o is held at the last head value when the queue is empty; it is don't-care while rsp_valid_o=0.

## Timing
- Reset values:
  - req_ready_o=0 during reset.
  - rsp_valid_o=0, bank_rsp_ready_o=0, outstanding_o=0, full_stall_cnt_o=0, orphan_rsp_o=0, rsp_sel_o=0.
- Zero-cycle response path: rsp_valid_o, rsp_sel_o and bank_rsp_ready_o are combinational from the queue head and the inputs.
- Push-to-head latency is 1 cycle minimum.
- outstanding_o is registered and updates the cycle after push/pop.
- Handshakes are valid/ready. A held rsp_valid_o must keep rsp_sel_o stable until the pop, which is guaranteed because the head only changes on pop.

## Configuration
- CACHE_BANK_RSP_ROUTER_PERF_EN defined:
  - full_stall_cnt_o is a 32-bit saturating counter.
  - It increments every cycle in which req_valid_i & bank_req_ready_i & full.
  - It saturates at 32'hFFFF_FFFF.
- Not defined: full_stall_cnt_o is tied to 0 and no counter flops are built.

## Structure
- Shared package cache_xbar_pkg holds:
  - the default MaxOutstanding constant;
  - a helper function for the occupancy width.
- mst_sel_t is passed as a parameter, consistent with the crossbar.
- One sub-module, cache_bank_rsp_route_fifo: the in-order index queue with push, pop, full, empty and occupancy.
- The top level holds the gating logic, the orphan flag and the optional counter.

## Test plan
- Single request from core 5, then a bank response 3 cycles later → rsp_valid_o=1 and rsp_sel_o=5 in the response cycle; outstanding_o goes 1 then 0.
- MaxOutstanding=4: push sources 1,2,3,0 back-to-back with responses withheld → req_ready_o=0 on the 5th cycle; responses emerge with rsp_sel_o=1,2,3,0 in order.
- Full queue with a simultaneous pop and a new request → the request is refused that cycle and accepted the next; occupancy 4→3→4.
- rsp_ready_i=0 for 3 cycles with bank_rsp_valid_i=1 → bank_rsp_ready_o=0, and rsp_sel_o stays stable until the pop.
- Bank response with the queue empty, and separately a reset with 2 outstanding then a late response → no rsp_valid_o, orphan_rsp_o=1, outstanding_o=0.
- With PERF_EN: hold a request against a full queue for 10 cycles → full_stall_cnt_o=10. Without PERF_EN → 0.
